// File: rtl/esp32_xfer_pkg.sv
// Shared types and constants for the XFER portal bus bridge.
// SUB0 header bit positions and memory-space codes match the SPI connector's decoder.
package esp32_xfer_pkg;

    localparam int XFER_ADDR_W   = 24;
    localparam int XFER_LEN_W    = 16;
    localparam int XFER_SPACE_W  = 3;
    localparam int XFER_PF_DEPTH = 4;

    localparam int SUB0_DIR_BIT   = 0;
    localparam int SUB0_SPACE_LSB = 1;
    localparam int SUB0_SPACE_MSB = 3;
    localparam int SUB0_INC_BIT   = 4;
    localparam int SUB0_CRC_BIT   = 5;

    localparam logic [2:0] SPACE_MAIN = 3'd0;
    localparam logic [2:0] SPACE_REG  = 3'd1;
    localparam logic [2:0] SPACE_ROM  = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_WAIT,
        ST_WR_BUS,
        ST_RD_FILL,
        ST_RD_DRAIN
    } xferState_e;

endpackage

// File: rtl/esp32_xfer_pf_fifo.sv
// Small synchronous prefetch FIFO with flush; pop on empty and push on full (without pop) are ignored.
module esp32_xfer_pf_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q;
    logic [PTR_W-1:0]  rdPtr_q;
    logic [CNT_W-1:0]  count_q;
    logic              doPush;
    logic              doPop;

    assign doPop   = pop_i && (count_q != '0);
    assign doPush  = push_i && ((count_q != CNT_W'(DEPTH)) || doPop);
    assign data_o  = mem_q[rdPtr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (doPush && !flush_i) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
            if (doPush && !doPop)      count_q <= count_q + CNT_W'(1);
            else if (doPop && !doPush) count_q <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/esp32_xfer_bus_bridge.sv
// Runs one XFER command at a time on the internal memory-space bus, single outstanding request,
// with a read prefetch FIFO so the SPI connector sees bytes right after its dummy byte.
module esp32_xfer_bus_bridge
    import esp32_xfer_pkg::*;
#(
    parameter int ADDR_W   = XFER_ADDR_W,
    parameter int LEN_W    = XFER_LEN_W,
    parameter int SPACE_W  = XFER_SPACE_W,
    parameter int PF_DEPTH = XFER_PF_DEPTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_dir_i,
    input  logic [SPACE_W-1:0] cmd_space_i,
    input  logic               cmd_inc_i,
    input  logic [ADDR_W-1:0]  cmd_addr_i,
    input  logic [LEN_W-1:0]   cmd_len_i,
    input  logic               abort_i,
    input  logic               wr_valid_i,
    input  logic [7:0]         wr_data_i,
    output logic               wr_ready_o,
    output logic               rd_valid_o,
    output logic [7:0]         rd_data_o,
    input  logic               rd_ready_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [SPACE_W-1:0] mem_space_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [7:0]         mem_wdata_o,
    input  logic               mem_ack_i,
    input  logic [7:0]         mem_rdata_i,
    output logic               busy_o,
    output logic               done_o
);

    localparam int CNT_W = $clog2(PF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] PF_FULL = CNT_W'(PF_DEPTH);

    xferState_e         state_q, state_d;
    logic [SPACE_W-1:0] space_q, space_d;
    logic               inc_q, inc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [LEN_W-1:0]   toIssue_q, toIssue_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               done_q, done_d;

    logic               abortHit;
    logic               ackSeen;
    logic               fifoPush;
    logic               fifoPop;
    logic               fifoEmpty;
    logic [CNT_W-1:0]   fifoCount;

    // Acks only count while a request is outstanding, so a late ack after abort is harmless.
    assign abortHit = abort_i && (state_q != ST_IDLE);
    assign ackSeen  = req_q && mem_ack_i;
    assign fifoPush = ackSeen && !we_q && !abortHit;
    assign fifoPop  = rd_ready_i && !fifoEmpty;

    esp32_xfer_pf_fifo #(
        .DEPTH  (PF_DEPTH),
        .DATA_W (8)
    ) u_pfFifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (abortHit),
        .push_i  (fifoPush),
        .data_i  (mem_rdata_i),
        .pop_i   (fifoPop),
        .data_o  (rd_data_o),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    always_comb begin
        state_d     = state_q;
        space_d     = space_q;
        inc_d       = inc_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        toIssue_d   = toIssue_q;
        req_d       = req_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        done_d      = 1'b0;

        if (abortHit) begin
            state_d     = ST_IDLE;
            req_d       = 1'b0;
            we_d        = 1'b0;
            remaining_d = '0;
            toIssue_d   = '0;
        end else begin
            if (ackSeen) begin
                req_d       = 1'b0;
                we_d        = 1'b0;
                remaining_d = remaining_q - LEN_W'(1);
                if (inc_q) addr_d = addr_q + ADDR_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        space_d     = cmd_space_i;
                        inc_d       = cmd_inc_i;
                        addr_d      = cmd_addr_i;
                        remaining_d = cmd_len_i;
                        toIssue_d   = cmd_len_i;
                        if (cmd_len_i == '0)  done_d  = 1'b1;
                        else if (!cmd_dir_i)  state_d = ST_WR_WAIT;
                        else                  state_d = ST_RD_FILL;
                    end
                end
                ST_WR_WAIT: begin
                    if (wr_valid_i) begin
                        wdata_d = wr_data_i;
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        state_d = ST_WR_BUS;
                    end
                end
                ST_WR_BUS: begin
                    if (ackSeen) begin
                        done_d  = (remaining_q == LEN_W'(1));
                        state_d = (remaining_q == LEN_W'(1)) ? ST_IDLE : ST_WR_WAIT;
                    end
                end
                // With nothing outstanding, occupancy alone bounds the prefetch window.
                ST_RD_FILL: begin
                    if (!req_q && (toIssue_q != '0) && (fifoCount < PF_FULL)) begin
                        req_d     = 1'b1;
                        toIssue_d = toIssue_q - LEN_W'(1);
                        if (toIssue_q == LEN_W'(1)) state_d = ST_RD_DRAIN;
                    end
                end
                ST_RD_DRAIN: begin
                    if ((remaining_q == '0) && fifoEmpty && !req_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            space_q     <= SPACE_W'(SPACE_MAIN);
            inc_q       <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
            toIssue_q   <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            space_q     <= space_d;
            inc_q       <= inc_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            toIssue_q   <= toIssue_d;
            req_q       <= req_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign wr_ready_o  = (state_q == ST_WR_WAIT);
    assign busy_o      = (state_q != ST_IDLE);
    assign rd_valid_o  = !fifoEmpty;
    assign done_o      = done_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_space_o = space_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_esp32_xfer_bus_bridge.sv
// Directed bench for esp32_xfer_bus_bridge with a behavioural bus responder and byte-level checks.
module tb_esp32_xfer_bus_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic        cmdDir = 1'b0;
    logic [2:0]  cmdSpace = 3'd0;
    logic        cmdInc = 1'b0;
    logic [23:0] cmdAddr = '0;
    logic [15:0] cmdLen = '0;
    logic        abort = 1'b0;
    logic        wrValid = 1'b0;
    logic [7:0]  wrData = '0;
    logic        wrReady;
    logic        rdValid;
    logic [7:0]  rdData;
    logic        rdReady = 1'b0;
    logic        memReq;
    logic        memWe;
    logic [2:0]  memSpace;
    logic [23:0] memAddr;
    logic [7:0]  memWdata;
    logic        memAck = 1'b0;
    logic [7:0]  memRdata = '0;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;

    logic [7:0]  memModel [256];
    logic        logWe [$];
    logic [23:0] logAddr [$];
    logic [7:0]  logData [$];
    logic [7:0]  rdGot [$];
    int          ackLatency = 1;
    logic        ackEnable = 1'b1;
    logic        lateAckReq = 1'b0;
    int          waitCnt = 0;
    int          doneCnt = 0;
    int          readReqs = 0;
    int          pops = 0;
    int          maxInflight = 0;
    logic        trackInflight = 1'b0;
    logic        prevRdReq = 1'b0;

    esp32_xfer_bus_bridge dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmdValid),
        .cmd_ready_o (cmdReady),
        .cmd_dir_i   (cmdDir),
        .cmd_space_i (cmdSpace),
        .cmd_inc_i   (cmdInc),
        .cmd_addr_i  (cmdAddr),
        .cmd_len_i   (cmdLen),
        .abort_i     (abort),
        .wr_valid_i  (wrValid),
        .wr_data_i   (wrData),
        .wr_ready_o  (wrReady),
        .rd_valid_o  (rdValid),
        .rd_data_o   (rdData),
        .rd_ready_i  (rdReady),
        .mem_req_o   (memReq),
        .mem_we_o    (memWe),
        .mem_space_o (memSpace),
        .mem_addr_o  (memAddr),
        .mem_wdata_o (memWdata),
        .mem_ack_i   (memAck),
        .mem_rdata_i (memRdata),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    // Bus responder: ack after ackLatency idle negedges, one-cycle pulse, logs each completed access.
    always @(negedge clk) begin
        if (memAck) begin
            memAck = 1'b0;
        end else if (lateAckReq) begin
            memAck = 1'b1;
        end else if (memReq && ackEnable) begin
            if (waitCnt >= ackLatency) begin
                memAck  = 1'b1;
                waitCnt = 0;
                logWe.push_back(memWe);
                logAddr.push_back(memAddr);
                if (memWe) begin
                    memModel[memAddr[7:0]] = memWdata;
                    logData.push_back(memWdata);
                end else begin
                    memRdata = memModel[memAddr[7:0]];
                    logData.push_back(memRdata);
                end
            end else begin
                waitCnt++;
            end
        end else begin
            waitCnt = 0;
        end
    end

    always @(negedge clk) begin
        if (done) doneCnt++;
        if (memReq && !memWe && !prevRdReq) readReqs++;
        prevRdReq = memReq && !memWe;
        if (rdValid && rdReady) pops++;
        if (trackInflight && (readReqs - pops) > maxInflight) maxInflight = readReqs - pops;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic dir, input logic [2:0] space, input logic inc,
                                 input logic [23:0] addr, input logic [15:0] len);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!cmdReady && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!cmdReady) checkOutput("cmd_ready_timeout", 32'd0, 32'd1);
        cmdValid = 1'b1;
        cmdDir   = dir;
        cmdSpace = space;
        cmdInc   = inc;
        cmdAddr  = addr;
        cmdLen   = len;
        @(negedge clk);
        cmdValid = 1'b0;
    endtask

    task automatic writeBytes(input int n, input logic [7:0] bytes [4]);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            while (!wrReady && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (!wrReady) begin
                checkOutput("wr_ready_timeout", 32'd0, 32'd1);
                return;
            end
            wrValid = 1'b1;
            wrData  = bytes[i];
            @(negedge clk);
            wrValid = 1'b0;
        end
    endtask

    // Leaves rd_ready high through the edge that pops the last sampled byte.
    task automatic readBytes(input int n);
        int guard;
        int taken;
        guard = 0;
        taken = 0;
        @(posedge clk);
        #1 rdReady = 1'b1;
        while (taken < n && guard < 400) begin
            @(negedge clk);
            if (rdValid) begin
                rdGot.push_back(rdData);
                taken++;
            end
            guard++;
        end
        if (taken < n) checkOutput("read_timeout", taken, n);
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle(input string tag);
        int guard;
        guard = 0;
        while (busy && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checkOutput(tag, {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int base;
        int d0;
        int r0;
        int guard;
        logic [23:0] wrapAddr [2];
        for (int i = 0; i < 256; i++) memModel[i] = 8'(i + 8'h80);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_cmd_ready", {31'd0, cmdReady}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_mem_req", {31'd0, memReq}, 32'd0);
        checkOutput("rst_rd_valid", {31'd0, rdValid}, 32'd0);
        checkOutput("rst_wr_ready", {31'd0, wrReady}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_mem_addr", {8'd0, memAddr}, 32'd0);

        $display("[TB] write 4 bytes at 0x20 inc");
        ackLatency = 1;
        base = logWe.size();
        d0 = doneCnt;
        applyStimulus(1'b0, 3'd0, 1'b1, 24'h000020, 16'd4);
        writeBytes(4, '{8'h01, 8'h02, 8'h03, 8'h04});
        waitIdle("wr1_busy_falls");
        checkOutput("wr1_count", logWe.size() - base, 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < logWe.size()) begin
                checkOutput("wr1_we", {31'd0, logWe[base+i]}, 32'd1);
                checkOutput("wr1_addr", {8'd0, logAddr[base+i]}, 32'h20 + i);
                checkOutput("wr1_data", {24'd0, logData[base+i]}, 32'h01 + i);
            end
        end
        checkOutput("wr1_done_pulses", doneCnt - d0, 32'd1);

        $display("[TB] read back 4 bytes, ack latency 2");
        ackLatency = 2;
        d0 = doneCnt;
        r0 = readReqs;
        rdGot.delete();
        maxInflight = 0;
        trackInflight = 1'b1;
        rdReady = 1'b1;
        applyStimulus(1'b1, 3'd0, 1'b1, 24'h000020, 16'd4);
        readBytes(4);
        waitIdle("rd1_busy_falls");
        trackInflight = 1'b0;
        for (int i = 0; i < 4; i++)
            if (i < rdGot.size()) checkOutput("rd1_data", {24'd0, rdGot[i]}, 32'h01 + i);
        checkOutput("rd1_reqs", readReqs - r0, 32'd4);
        checkOutput("rd1_inflight_le4", {31'd0, maxInflight <= 4}, 32'd1);
        checkOutput("rd1_done_pulses", doneCnt - d0, 32'd1);

        $display("[TB] read 8 bytes with stalled consumer");
        ackLatency = 0;
        rdReady = 1'b0;
        d0 = doneCnt;
        r0 = readReqs;
        rdGot.delete();
        applyStimulus(1'b1, 3'd0, 1'b1, 24'h000030, 16'd8);
        repeat (20) @(negedge clk);
        checkOutput("stall_reqs", readReqs - r0, 32'd4);
        checkOutput("stall_mem_req_low", {31'd0, memReq}, 32'd0);
        checkOutput("stall_rd_valid", {31'd0, rdValid}, 32'd1);
        readBytes(8);
        waitIdle("stall_busy_falls");
        for (int i = 0; i < 8; i++)
            if (i < rdGot.size()) checkOutput("stall_data", {24'd0, rdGot[i]}, 32'hB0 + i);
        checkOutput("stall_total_reqs", readReqs - r0, 32'd8);
        checkOutput("stall_done_pulses", doneCnt - d0, 32'd1);

        $display("[TB] fixed-address write and address wrap");
        ackLatency = 1;
        rdReady = 1'b0;
        base = logWe.size();
        applyStimulus(1'b0, 3'd0, 1'b0, 24'h000040, 16'd3);
        writeBytes(3, '{8'hAA, 8'hBB, 8'hCC, 8'h00});
        waitIdle("noinc_busy_falls");
        checkOutput("noinc_count", logWe.size() - base, 32'd3);
        for (int i = 0; i < 3; i++)
            if (base + i < logAddr.size()) checkOutput("noinc_addr", {8'd0, logAddr[base+i]}, 32'h40);
        base = logWe.size();
        wrapAddr[0] = 24'hFFFFFF;
        wrapAddr[1] = 24'h000000;
        applyStimulus(1'b0, 3'd0, 1'b1, 24'hFFFFFF, 16'd2);
        writeBytes(2, '{8'h11, 8'h22, 8'h00, 8'h00});
        waitIdle("wrap_busy_falls");
        checkOutput("wrap_count", logWe.size() - base, 32'd2);
        for (int i = 0; i < 2; i++)
            if (base + i < logAddr.size()) checkOutput("wrap_addr", {8'd0, logAddr[base+i]}, {8'd0, wrapAddr[i]});

        $display("[TB] zero-length command");
        r0 = readReqs;
        applyStimulus(1'b1, 3'd0, 1'b1, 24'h000060, 16'd0);
        checkOutput("len0_done_next", {31'd0, done}, 32'd1);
        checkOutput("len0_busy", {31'd0, busy}, 32'd0);
        checkOutput("len0_mem_req", {31'd0, memReq}, 32'd0);
        @(negedge clk);
        checkOutput("len0_done_one_cycle", {31'd0, done}, 32'd0);
        checkOutput("len0_no_reads", readReqs - r0, 32'd0);

        $display("[TB] abort mid-read with request pending");
        ackLatency = 1;
        rdGot.delete();
        d0 = doneCnt;
        applyStimulus(1'b1, 3'd0, 1'b1, 24'h000020, 16'd8);
        readBytes(2);
        rdReady = 1'b0;
        ackEnable = 1'b0;
        for (int i = 0; i < 2; i++)
            if (i < rdGot.size()) checkOutput("abort_pre_data", {24'd0, rdGot[i]}, 32'h01 + i);
        guard = 0;
        while (!memReq && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("abort_req_pending", {31'd0, memReq}, 32'd1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_mem_req", {31'd0, memReq}, 32'd0);
        checkOutput("abort_rd_valid", {31'd0, rdValid}, 32'd0);
        checkOutput("abort_cmd_ready", {31'd0, cmdReady}, 32'd1);
        @(posedge clk);
        #1 lateAckReq = 1'b1;
        @(posedge clk);
        #1 lateAckReq = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("late_ack_rd_valid", {31'd0, rdValid}, 32'd0);
        checkOutput("late_ack_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_no_done", doneCnt - d0, 32'd0);
        ackEnable = 1'b1;
        base = logWe.size();
        d0 = doneCnt;
        applyStimulus(1'b0, 3'd0, 1'b1, 24'h000050, 16'd1);
        writeBytes(1, '{8'h77, 8'h00, 8'h00, 8'h00});
        waitIdle("post_abort_busy_falls");
        checkOutput("post_abort_count", logWe.size() - base, 32'd1);
        if (base < logWe.size()) begin
            checkOutput("post_abort_we", {31'd0, logWe[base]}, 32'd1);
            checkOutput("post_abort_addr", {8'd0, logAddr[base]}, 32'h50);
            checkOutput("post_abort_data", {24'd0, logData[base]}, 32'h77);
        end
        checkOutput("post_abort_done", doneCnt - d0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/esp32_xfer_bus_bridge.md
Name: esp32_xfer_bus_bridge

Overview:
Downstream of esp32_spi_connector. Consumes decoded XFER portal commands (SUB0/ADDR/LEN) and the byte stream, and runs one single-outstanding request at a time on the FPGA-internal memory-space bus. For reads it prefetches into a small FIFO to hide bus latency, so the connector sees bytes after its one dummy byte. Handles abort on SPI reframe (sync or idle timeout).

Parameters:
ADDR_W, 24, bus/XFER address width
LEN_W, 16, transfer length width (bytes)
SPACE_W, 3, memory-space selector width
PF_DEPTH, 4, read prefetch FIFO depth (power of 2, >=2)

Ports:
clk  in  1  core clock (54 MHz)
rst  in  1  synchronous active-high reset
cmd_valid  in  1  XFER header complete
cmd_ready  out  1  bridge idle, header accepted
cmd_dir  in  1  0=write, 1=read
cmd_space  in  SPACE_W  target space
cmd_inc  in  1  1=post-increment address
cmd_addr  in  ADDR_W  start address
cmd_len  in  LEN_W  byte count
abort  in  1  connector reframed; kill transfer
wr_valid  in  1  write byte available
wr_data  in  8  write byte
wr_ready  out  1  write byte accepted
rd_valid  out  1  prefetched byte available
rd_data  out  8  read byte
rd_ready  in  1  connector takes byte
mem_req  out  1  bus request, held until mem_ack
mem_we  out  1  write strobe
mem_space  out  SPACE_W  space
mem_addr  out  ADDR_W  address
mem_wdata  out  8  write data
mem_ack  in  1  one-cycle completion; mem_rdata valid same cycle
mem_rdata  in  8  read data
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at normal completion

Behaviour:
- Reset: state IDLE; cmd_ready=1; wr_ready, rd_valid, mem_req, mem_we, busy, done=0; mem_addr, mem_wdata, mem_space=0; remaining=0; FIFO empty.
- States: IDLE, WR_WAIT, WR_BUS, RD_FILL, RD_DRAIN.
- IDLE: cmd_valid&cmd_ready latches space/inc/addr/len. len==0 -> done pulse next cycle, stay IDLE. dir=0 -> WR_WAIT; dir=1 -> RD_FILL. busy=1 in all non-IDLE states.
- WR_WAIT: wr_ready=1. On wr_valid: capture byte, mem_req=1, mem_we=1 next cycle -> WR_BUS. wr_ready=0 in WR_BUS (backpressure).
- WR_BUS: hold req/addr/data stable until mem_ack. On ack: remaining-1; if inc, addr+1 modulo 2^ADDR_W (0xFFFFFF wraps to 0x000000). remaining reaches 0 -> done pulse, IDLE; else WR_WAIT.
- RD_FILL: issue read (mem_we=0) while FIFO has a free slot and issued<len. On mem_ack: push mem_rdata, advance addr per inc. All len reads issued -> RD_DRAIN.
- FIFO: rd_valid=!empty; pop on rd_valid&rd_ready. Push and pop same cycle allowed at any occupancy. Never issue request when occupancy+outstanding==PF_DEPTH.
- First-byte latency: cmd accept to rd_valid <= 3 cycles + bus ack latency.
- RD_DRAIN: FIFO empty and remaining==0 -> done pulse, IDLE.
- rd_ready while empty: ignored, no underflow. wr_valid outside WR_WAIT: ignored (wr_ready=0).
- abort (any state, priority over all events): next cycle IDLE, FIFO flushed, busy=0, no done. If mem_req active and ack not yet seen, mem_req drops; a late ack in IDLE is ignored. Abort in IDLE no effect.
- cmd_valid while busy: cmd_ready=0, not latched.
- Simultaneous ack and abort: abort wins; write counts as performed on bus, nothing reported.

Decomposition:
- Package esp32_xfer_pkg: state enum, SUB0 bit positions (DIR bit0, SPACE bits3:1, INC bit4, CRC bit5), space constants (SPACE_MAIN=0 etc.), width localparams.
- Sub-module esp32_xfer_pf_fifo: sync FIFO, depth PF_DEPTH, with flush, count output.

Test Plan:
- Write space 0, addr 0x20, inc=1, len 4, bytes 01..04 -> four bus writes at 0x20..0x23 with data 01..04, one done pulse, busy falls.
- Read back same range, mem_ack 2 cycles after req, rd_ready held 1 -> rd_data 01,02,03,04 in order; at most 4 outstanding+buffered; done after last pop.
- Read len 8, rd_ready stalled 20 cycles -> exactly PF_DEPTH reads issued then mem_req low; on release remaining 4 fetched, bytes in address order.
- inc=0 write len 3 at 0x000040 -> all three writes to 0x40; start 0xFFFFFF inc=1 len 2 -> addresses 0xFFFFFF, 0x000000.
- len=0 command -> no mem_req, done one cycle after accept.
- abort during read after 2 bytes popped, mem_req pending -> IDLE next cycle, rd_valid=0, no done, late mem_ack ignored; new write command accepted afterwards.
